// File: rtl/sdiv_32_32.sv
// Iterative 32/32 restoring divider with RISC-V DIV/DIVU/REM/REMU result semantics.
// Optional build macro SDIV_ZERO_EARLY_OUT_EN: divide-by-zero skips the iteration phase.
module sdiv_32_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [32:0] ai,
  input  logic [32:0] bi,
  input  logic        req,
  output logic [31:0] q,
  output logic [31:0] rem,
  output logic        busy,
  output logic        rdy
);

  localparam int unsigned ITER = 32;
  localparam int unsigned W    = 32;
  localparam int unsigned CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   prem, prem_nx;
  logic [W-1:0]   dvd, dvd_nx;
  logic [W-1:0]   dvs, dvs_nx;
  logic [W-1:0]   a_raw, a_raw_nx;
  logic           sign_a, sign_a_nx;
  logic           sign_b, sign_b_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [W-1:0]   q_nx, rem_nx;
  logic           busy_nx, rdy_nx;

  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     prem_sh;
  logic [W:0]     trial;

  // Operand magnitudes from the 33-bit extended inputs
  assign a_mag = ai[W] ? W'(-ai) : ai[W-1:0];
  assign b_mag = bi[W] ? W'(-bi) : bi[W-1:0];

  // Restoring step: prem_sh < 2*dvs always, so the 33-bit sign bit is exact
  assign prem_sh = {prem, dvd[W-1]};
  assign trial   = prem_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prem   <= '0;
      dvd    <= '0;
      dvs    <= '0;
      a_raw  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      q      <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      prem   <= prem_nx;
      dvd    <= dvd_nx;
      dvs    <= dvs_nx;
      a_raw  <= a_raw_nx;
      sign_a <= sign_a_nx;
      sign_b <= sign_b_nx;
      cnt    <= cnt_nx;
      q      <= q_nx;
      rem    <= rem_nx;
      busy   <= busy_nx;
      rdy    <= rdy_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    prem_nx   = prem;
    dvd_nx    = dvd;
    dvs_nx    = dvs;
    a_raw_nx  = a_raw;
    sign_a_nx = sign_a;
    sign_b_nx = sign_b;
    cnt_nx    = cnt;
    q_nx      = q;
    rem_nx    = rem;

    case (state)
      IDLE: begin
        if (req) begin
          sign_a_nx = ai[W];
          sign_b_nx = bi[W];
          dvd_nx    = a_mag;
          dvs_nx    = b_mag;
          a_raw_nx  = ai[W-1:0];
          prem_nx   = '0;
          cnt_nx    = '0;
          state_nx  = CALC;
`ifdef SDIV_ZERO_EARLY_OUT_EN
          if (bi == '0) state_nx = FIX;
`else
`endif
        end
      end
      CALC: begin
        // Quotient bits shift in where dividend bits shift out
        prem_nx = trial[W] ? prem_sh[W-1:0] : trial[W-1:0];
        dvd_nx  = {dvd[W-2:0], ~trial[W]};
        cnt_nx  = cnt + CW'(1);
        if (cnt == CW'(ITER - 1)) state_nx = FIX;
      end
      FIX: begin
        if (dvs == '0) begin
          q_nx   = '1;
          rem_nx = a_raw;
        end else begin
          q_nx   = (sign_a ^ sign_b) ? W'(-dvd) : dvd;
          rem_nx = sign_a ? W'(-prem) : prem;
        end
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
    rdy_nx  = (state_nx == DONE);
  end

endmodule

// File: tb/tb_sdiv_32_32.sv
// Self-checking bench for sdiv_32_32: directed corner cases, control scenarios and random ops.
module tb_sdiv_32_32;

  logic        clk;
  logic        rst_n;
  logic [32:0] ai;
  logic [32:0] bi;
  logic        req;
  logic [31:0] q;
  logic [31:0] rem;
  logic        busy;
  logic        rdy;

  int n_cmp = 0;
  int n_err = 0;

  sdiv_32_32 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ai   (ai),
    .bi   (bi),
    .req  (req),
    .q    (q),
    .rem  (rem),
    .busy (busy),
    .rdy  (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RISC-V DIV/REM semantics from plain 64-bit signed arithmetic; result {q, rem}
  function automatic logic [63:0] ref_div(input logic [32:0] a, input logic [32:0] b);
    longint sa, sb, qq, rr;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return {32'hFFFF_FFFF, a[31:0]};
    qq = sa / sb;
    rr = sa % sb;
    return {qq[31:0], rr[31:0]};
  endfunction

  function automatic int exp_lat(input logic [32:0] b);
`ifdef SDIV_ZERO_EARLY_OUT_EN
    return (b == '0) ? 2 : 34;
`else
    return (b == '0) ? 34 : 34;
`endif
  endfunction

  function automatic logic [32:0] rand_opnd(input bit sgn, input int kind);
    logic [31:0] x;
    case (kind)
      0:       x = 32'($urandom_range(0, 20));
      1:       x = 32'h8000_0000;
      2:       x = 32'hFFFF_FFFF;
      default: x = $urandom;
    endcase
    return sgn ? {x[31], x} : {1'b0, x};
  endfunction

  // Accept one op, scramble inputs after acceptance, return cycles from acceptance to rdy
  task automatic run_op(input logic [32:0] a, input logic [32:0] b, output int lat);
    int n;
    @(negedge clk);
    ai  = a;
    bi  = b;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    ai  = {1'($urandom), 32'($urandom)};
    bi  = {1'($urandom), 32'($urandom)};
    n   = 1;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) check("rdy_timeout", 64'(rdy), 64'd1);
    lat = n;
  endtask

  task automatic op_and_check(input string tag, input logic [32:0] a, input logic [32:0] b);
    int          lat;
    logic [63:0] e;
    e = ref_div(a, b);
    run_op(a, b, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(b)));
    check({tag, "_q"}, 64'(q), 64'(e[63:32]));
    check({tag, "_rem"}, 64'(rem), 64'(e[31:0]));
  endtask

  initial begin
    int          lat, n, seen;
    int          rdy_t[3];
    logic [63:0] e;
    logic [32:0] a, b;
    bit          sgn;

    rst_n = 1'b0;
    req   = 1'b0;
    ai    = '0;
    bi    = '0;
    repeat (3) @(negedge clk);
    check("rst_q", 64'(q), 64'd0);
    check("rst_rem", 64'(rem), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdy", 64'(rdy), 64'd0);
    rst_n = 1'b1;

    // Basic op with full timing checks
    run_op(33'd100, 33'd7, lat);
    check("basic_lat", 64'(lat), 64'd34);
    check("basic_q", 64'(q), 64'd14);
    check("basic_rem", 64'(rem), 64'd2);
    check("basic_busy_at_rdy", 64'(busy), 64'd1);
    @(negedge clk);
    check("basic_rdy_low", 64'(rdy), 64'd0);
    check("basic_busy_low", 64'(busy), 64'd0);

    op_and_check("neg_dividend", {1'b1, 32'hFFFF_FFF9}, 33'd2);
    check("neg_dividend_q_const", 64'(q), 64'hFFFF_FFFD);
    check("neg_dividend_rem_const", 64'(rem), 64'hFFFF_FFFF);
    op_and_check("neg_divisor", 33'd7, {1'b1, 32'hFFFF_FFFE});
    check("neg_divisor_rem_const", 64'(rem), 64'd1);
    op_and_check("unsigned_big", {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'd16});
    check("unsigned_big_q_const", 64'(q), 64'h0FFF_FFFF);
    op_and_check("div_zero", 33'd1234, 33'd0);
    check("div_zero_q_const", 64'(q), 64'hFFFF_FFFF);
    check("div_zero_rem_const", 64'(rem), 64'd1234);
    op_and_check("div_zero_neg", {1'b1, 32'hFFFF_FF00}, 33'd0);
    op_and_check("overflow", {1'b1, 32'h8000_0000}, {1'b1, 32'hFFFF_FFFF});
    check("overflow_q_const", 64'(q), 64'h8000_0000);
    check("overflow_rem_const", 64'(rem), 64'd0);

    // req held high: back-to-back ops every 35 cycles
    @(negedge clk);
    ai  = {1'b1, 32'hFFFF_FC19};
    bi  = 33'd13;
    req = 1'b1;
    e   = ref_div(ai, bi);
    n    = 0;
    seen = 0;
    while (seen < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (rdy) begin
        rdy_t[seen] = n;
        check("b2b_q", 64'(q), 64'(e[63:32]));
        check("b2b_rem", 64'(rem), 64'(e[31:0]));
        seen++;
        if (seen == 3) req = 1'b0;
      end
    end
    check("b2b_count", 64'(seen), 64'd3);
    if (seen == 3) begin
      check("b2b_first", 64'(rdy_t[0]), 64'd34);
      check("b2b_gap1", 64'(rdy_t[1] - rdy_t[0]), 64'd35);
      check("b2b_gap2", 64'(rdy_t[2] - rdy_t[1]), 64'd35);
    end
    req = 1'b0;
    @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);

    // req while busy is ignored
    e = ref_div(33'd5000, 33'd3);
    @(negedge clk);
    ai  = 33'd5000;
    bi  = 33'd3;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n   = 1;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        ai  = 33'd999;
        bi  = 33'd10;
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
    end
    check("ign_lat", 64'(n), 64'd34);
    check("ign_q", 64'(q), 64'(e[63:32]));
    check("ign_rem", 64'(rem), 64'(e[31:0]));
    @(negedge clk);
    check("ign_not_queued", 64'(busy), 64'd0);

    // Reset mid-operation abandons the op
    @(negedge clk);
    ai  = 33'd77;
    bi  = 33'd5;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_q", 64'(q), 64'd0);
    check("mid_rst_rem", 64'(rem), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rdy) seen++;
    end
    check("mid_rst_no_rdy", 64'(seen), 64'd0);

    // Randomized signed and unsigned ops against the model
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a   = rand_opnd(sgn, int'($urandom_range(0, 5)));
      b   = rand_opnd(sgn, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) b = sgn ? {1'b1, 32'hFFFF_FFFF} : 33'd1;
      op_and_check("rand", a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
